issue_scoreboard: RTL and testbench

//  In-order single-entry issue stage, directly downstream of instruction decode.

---
 rtl/issue_scoreboard_pkg.sv | 37 +++
 rtl/issue_scoreboard_scoreboard_regs.sv | 38 +++
 rtl/issue_scoreboard.sv | 129 ++++++++++++
 tb/tb_issue_scoreboard.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue stage: widths, routed opcodes, id_iss_ctrl
// bit positions and the functional-unit encoding.
package issue_scoreboard_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 16;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Bit positions inside id_iss_ctrl; bits [2:0] are reserved zero.
  localparam int unsigned CTRL_SELALUSHIFT = 15;
  localparam int unsigned CTRL_SELIMREGB   = 14;
  localparam int unsigned CTRL_ALUOP_HI    = 13;
  localparam int unsigned CTRL_ALUOP_LO    = 11;
  localparam int unsigned CTRL_UNSIG       = 10;
  localparam int unsigned CTRL_SHIFTOP_HI  = 9;
  localparam int unsigned CTRL_SHIFTOP_LO  = 8;
  localparam int unsigned CTRL_READMEM     = 7;
  localparam int unsigned CTRL_WRITEMEM    = 6;
  localparam int unsigned CTRL_SELWSOURCE  = 5;
  localparam int unsigned CTRL_WRITEOV     = 4;
  localparam int unsigned CTRL_SELREGDEST  = 3;

  typedef enum logic {
    FU_ALU = 1'b0,
    FU_MEM = 1'b1
  } fu_e;

  // Loads and stores go to MEM; everything else, including MUL, goes to the ALU.
  function automatic fu_e fu_route(input logic [6:0] opcode);
    return ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) ? FU_MEM : FU_ALU;
  endfunction

endpackage

// File: rtl/issue_scoreboard_scoreboard_regs.sv
// Pending-write scoreboard: one bit per architectural register.
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   clr_en, clr_addr      clear a pending bit (writeback)
//   set_en, set_addr      set a pending bit (dispatch); set wins over clear
//   sb                    registered pending vector, bit 0 always 0
module scoreboard_regs
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NumRegs = NREGS,
  parameter int unsigned AddrW   = REG_AW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr_en,
  input  logic [AddrW-1:0]   clr_addr,
  input  logic               set_en,
  input  logic [AddrW-1:0]   set_addr,
  output logic [NumRegs-1:0] sb
);

  logic [NumRegs-1:0] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_addr] = 1'b0;
    if (set_en) sb_d[set_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign sb = sb_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry in-order issue stage. Buffers one decoded instruction, blocks it
// on RAW/WAW hazards against the pending-write scoreboard, and dispatches it to
// the ALU or MEM unit with a valid/ready handshake.
// Ports:
//   clock, reset               clock and asynchronous active-high reset
//   id_iss_*                   decoded instruction from decode (id_iss_valid qualifies)
//   iss_stall                  decode must hold its instruction
//   iss_reg_addra/b, reg_iss_* asynchronous register-file read of the buffered sources
//   iss_alu_valid/alu_iss_ready, iss_mem_valid/mem_iss_ready  dispatch handshakes
//   iss_fu_*                   dispatch payload
//   wb_iss_valid, wb_iss_addr  writeback clears a pending bit
//   iss_scoreboard             pending-write vector
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              id_iss_valid,
  input  logic [6:0]        id_iss_opcode,
  input  logic [2:0]        id_iss_funct3,
  input  logic [6:0]        id_iss_funct7,
  input  logic [4:0]        id_iss_addra,
  input  logic [4:0]        id_iss_addrb,
  input  logic [4:0]        id_iss_regdest,
  input  logic              id_iss_writereg,
  input  logic [CTRL_W-1:0] id_iss_ctrl,
  input  logic [XLEN-1:0]   id_iss_imedext,
  output logic              iss_stall,
  output logic [4:0]        iss_reg_addra,
  output logic [4:0]        iss_reg_addrb,
  input  logic [XLEN-1:0]   reg_iss_dataa,
  input  logic [XLEN-1:0]   reg_iss_datab,
  output logic              iss_alu_valid,
  input  logic              alu_iss_ready,
  output logic              iss_mem_valid,
  input  logic              mem_iss_ready,
  output logic [CTRL_W-1:0] iss_fu_ctrl,
  output logic [XLEN-1:0]   iss_fu_opa,
  output logic [XLEN-1:0]   iss_fu_opb,
  output logic [XLEN-1:0]   iss_fu_imm,
  output logic [4:0]        iss_fu_rd,
  output logic              iss_fu_writereg,
  input  logic              wb_iss_valid,
  input  logic [4:0]        wb_iss_addr,
  output logic [NREGS-1:0]  iss_scoreboard
);

  // funct3/funct7 are already folded into id_iss_ctrl by decode.
  logic unused_funct;
  assign unused_funct = ^{id_iss_funct3, id_iss_funct7};

  logic              buf_valid_q;
  logic [6:0]        opcode_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic              wr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   imm_q;

  logic [NREGS-1:0]  sb;
  logic              raw, waw, issue_ok, fire, accept, sb_set;
  fu_e               unit;

  assign unit = fu_route(opcode_q);

  // rs2 is not read when the immediate replaces operand B.
  assign raw = (sb[rs1_q] && (rs1_q != '0)) ||
               (sb[rs2_q] && (rs2_q != '0) && !ctrl_q[CTRL_SELIMREGB]);
  assign waw = wr_q && (rd_q != '0) && sb[rd_q];

  // Hazards only clear while waiting (sets happen only on our own fire), so a
  // raised valid is never withdrawn before it fires.
  assign issue_ok      = buf_valid_q && !raw && !waw;
  assign iss_alu_valid = issue_ok && (unit == FU_ALU);
  assign iss_mem_valid = issue_ok && (unit == FU_MEM);
  assign fire          = (iss_alu_valid && alu_iss_ready) || (iss_mem_valid && mem_iss_ready);
  assign iss_stall     = buf_valid_q && !fire;
  assign accept        = id_iss_valid && !iss_stall;
  assign sb_set        = fire && wr_q && (rd_q != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      opcode_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      wr_q        <= 1'b0;
      ctrl_q      <= '0;
      imm_q       <= '0;
    end else if (accept) begin
      buf_valid_q <= 1'b1;
      opcode_q    <= id_iss_opcode;
      rs1_q       <= id_iss_addra;
      rs2_q       <= id_iss_addrb;
      rd_q        <= id_iss_regdest;
      wr_q        <= id_iss_writereg;
      ctrl_q      <= id_iss_ctrl;
      imm_q       <= id_iss_imedext;
    end else if (fire) begin
      buf_valid_q <= 1'b0;
    end
  end

  scoreboard_regs #(
    .NumRegs (NREGS),
    .AddrW   (REG_AW)
  ) u_scoreboard_regs (
    .clock    (clock),
    .reset    (reset),
    .clr_en   (wb_iss_valid),
    .clr_addr (wb_iss_addr),
    .set_en   (sb_set),
    .set_addr (rd_q),
    .sb       (sb)
  );

  assign iss_scoreboard  = sb;
  assign iss_reg_addra   = rs1_q;
  assign iss_reg_addrb   = rs2_q;
  assign iss_fu_ctrl     = ctrl_q;
  assign iss_fu_imm      = imm_q;
  assign iss_fu_rd       = rd_q;
  assign iss_fu_writereg = wr_q;
  // Operands read as zero while the buffer is empty.
  assign iss_fu_opa      = buf_valid_q ? reg_iss_dataa : '0;
  assign iss_fu_opb      = !buf_valid_q ? '0 :
                           (ctrl_q[CTRL_SELIMREGB] ? imm_q : reg_iss_datab);

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic        wr;
    logic [15:0] ctrl;
    logic [31:0] imm;
  } ins_t;

  typedef struct {
    ins_t        ins;
    logic        exp_mem;
    logic [31:0] exp_sb;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_iss_valid;
  ins_t        cur;
  logic        iss_stall;
  logic [4:0]  iss_reg_addra, iss_reg_addrb;
  logic [31:0] reg_iss_dataa, reg_iss_datab;
  logic        iss_alu_valid, alu_iss_ready, iss_mem_valid, mem_iss_ready;
  logic [15:0] iss_fu_ctrl;
  logic [31:0] iss_fu_opa, iss_fu_opb, iss_fu_imm;
  logic [4:0]  iss_fu_rd;
  logic        iss_fu_writereg;
  logic        wb_iss_valid;
  logic [4:0]  wb_iss_addr;
  logic [31:0] iss_scoreboard;

  int total = 0;
  int bad   = 0;
  logic [118:0] q[$];
  vec_t vecs[$];

  always #5 clock = ~clock;

  // Register-file model: x0 reads zero, others a recognisable pattern.
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'hC0DE_0000 + {27'd0, a} * 32'h0000_0101);
  endfunction

  assign reg_iss_dataa = rf(iss_reg_addra);
  assign reg_iss_datab = rf(iss_reg_addrb);

  issue_scoreboard dut (
    .clock           (clock),
    .reset           (reset),
    .id_iss_valid    (id_iss_valid),
    .id_iss_opcode   (cur.opc),
    .id_iss_funct3   (cur.f3),
    .id_iss_funct7   (cur.f7),
    .id_iss_addra    (cur.rs1),
    .id_iss_addrb    (cur.rs2),
    .id_iss_regdest  (cur.rd),
    .id_iss_writereg (cur.wr),
    .id_iss_ctrl     (cur.ctrl),
    .id_iss_imedext  (cur.imm),
    .iss_stall       (iss_stall),
    .iss_reg_addra   (iss_reg_addra),
    .iss_reg_addrb   (iss_reg_addrb),
    .reg_iss_dataa   (reg_iss_dataa),
    .reg_iss_datab   (reg_iss_datab),
    .iss_alu_valid   (iss_alu_valid),
    .alu_iss_ready   (alu_iss_ready),
    .iss_mem_valid   (iss_mem_valid),
    .mem_iss_ready   (mem_iss_ready),
    .iss_fu_ctrl     (iss_fu_ctrl),
    .iss_fu_opa      (iss_fu_opa),
    .iss_fu_opb      (iss_fu_opb),
    .iss_fu_imm      (iss_fu_imm),
    .iss_fu_rd       (iss_fu_rd),
    .iss_fu_writereg (iss_fu_writereg),
    .wb_iss_valid    (wb_iss_valid),
    .wb_iss_addr     (wb_iss_addr),
    .iss_scoreboard  (iss_scoreboard)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic wr, input logic [15:0] ctrl, input logic [31:0] imm);
    ins_t i;
    i.opc = opc; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    i.wr = wr; i.ctrl = ctrl; i.imm = imm;
    return i;
  endfunction

  // Expected dispatch record {mem, ctrl, opa, opb, imm, rd, wr}.
  function automatic logic [118:0] expect_of(input ins_t i);
    logic        mem;
    logic [31:0] opb;
    mem = (i.opc == 7'h03) || (i.opc == 7'h23);
    opb = i.ctrl[14] ? i.imm : rf(i.rs2);
    return {mem, i.ctrl, rf(i.rs1), opb, i.imm, i.rd, i.wr};
  endfunction

  // Scoreboard monitor: retire the oldest expectation on each fire, then queue
  // the instruction accepted in this cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (iss_alu_valid && iss_mem_valid) begin
        total++; bad++;
        $display("FAIL both_valid: got alu=1 mem=1 want at most one");
      end
      if ((iss_alu_valid && alu_iss_ready) || (iss_mem_valid && mem_iss_ready)) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dispatch: got fire want none");
        end else begin
          chk("dispatch_payload",
              {9'd0, iss_mem_valid, iss_fu_ctrl, iss_fu_opa, iss_fu_opb, iss_fu_imm,
               iss_fu_rd, iss_fu_writereg},
              {9'd0, q.pop_front()});
        end
      end
      if (id_iss_valid && !iss_stall) q.push_back(expect_of(cur));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input ins_t i);
    cur = i;
    id_iss_valid = 1'b1;
  endtask

  // Writeback of one register during one cycle; starts and ends just after a posedge.
  task automatic wb(input logic [4:0] a);
    wb_iss_valid = 1'b1;
    wb_iss_addr  = a;
    tick();
    wb_iss_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] opa_hold;
    reset = 1'b1;
    id_iss_valid = 1'b0;
    cur = mk(7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0, 32'h0);
    alu_iss_ready = 1'b1;
    mem_iss_ready = 1'b1;
    wb_iss_valid = 1'b0;
    wb_iss_addr = 5'd0;

    @(negedge clock);
    chk("reset_ctl", {iss_stall, iss_alu_valid, iss_mem_valid, iss_scoreboard}, 35'd0);
    chk("reset_payload", {iss_fu_ctrl, iss_fu_opa, iss_fu_opb, iss_fu_imm, iss_fu_rd,
                          iss_fu_writereg, iss_reg_addra, iss_reg_addrb}, 118'd0);
    tick();
    reset = 1'b0;

    // Table: independent instructions from a clean scoreboard.
    vecs.push_back('{mk(7'h33, 3'h0, 7'h00, 5'd1, 5'd2, 5'd3, 1'b1, 16'h0000, 32'h0), 1'b0, 32'h0000_0008});
    vecs.push_back('{mk(7'h13, 3'h0, 7'h00, 5'd2, 5'd27, 5'd4, 1'b1, 16'h4000, 32'hFFFF_FFFB), 1'b0, 32'h0000_0010});
    vecs.push_back('{mk(7'h03, 3'h2, 7'h00, 5'd3, 5'd8, 5'd11, 1'b1, 16'h4080, 32'h8), 1'b1, 32'h0000_0800});
    vecs.push_back('{mk(7'h23, 3'h2, 7'h00, 5'd5, 5'd4, 5'd12, 1'b0, 16'h4040, 32'hC), 1'b1, 32'h0});
    vecs.push_back('{mk(7'h33, 3'h0, 7'h01, 5'd6, 5'd7, 5'd20, 1'b1, 16'h1800, 32'h0), 1'b0, 32'h0010_0000});
    vecs.push_back('{mk(7'h63, 3'h0, 7'h00, 5'd1, 5'd2, 5'd8, 1'b0, 16'h0000, 32'h10), 1'b0, 32'h0});
    vecs.push_back('{mk(7'h37, 3'h0, 7'h00, 5'd0, 5'd0, 5'd31, 1'b1, 16'h4000, 32'h1234_5000), 1'b0, 32'h8000_0000});
    vecs.push_back('{mk(7'h33, 3'h0, 7'h00, 5'd1, 5'd2, 5'd0, 1'b1, 16'h0000, 32'h0), 1'b0, 32'h0});

    foreach (vecs[k]) begin
      drive(vecs[k].ins);
      @(negedge clock);
      tick();
      id_iss_valid = 1'b0;
      @(negedge clock);
      chk($sformatf("vec%0d_unit", k), {iss_alu_valid, iss_mem_valid, iss_stall},
          vecs[k].exp_mem ? 3'b010 : 3'b100);
      tick();
      @(negedge clock);
      chk($sformatf("vec%0d_sb", k), iss_scoreboard, vecs[k].exp_sb);
      tick();
      wb(vecs[k].ins.rd);
      @(negedge clock);
      chk($sformatf("vec%0d_sb_clr", k), iss_scoreboard, 32'h0);
      tick();
    end

    // 1: ADDI x5,x0,3 dispatches one cycle after accept and sets sb[5].
    drive(mk(7'h13, 3'h0, 7'h00, 5'd0, 5'd3, 5'd5, 1'b1, 16'h4000, 32'd3));
    @(negedge clock);
    chk("t1_empty_no_valid", {iss_alu_valid, iss_stall}, 2'b00);
    tick();
    id_iss_valid = 1'b0;
    @(negedge clock);
    chk("t1_alu_valid", {iss_alu_valid, iss_mem_valid, iss_stall}, 3'b100);
    tick();
    @(negedge clock);
    chk("t1_sb", iss_scoreboard, 32'h20);
    tick();

    // 2: ADD x6,x5,x5 waits on sb[5]; no bypass from the writeback cycle.
    drive(mk(7'h33, 3'h0, 7'h00, 5'd5, 5'd5, 5'd6, 1'b1, 16'h0000, 32'h0));
    tick();
    id_iss_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk($sformatf("t2_raw_stall%0d", c), {iss_alu_valid, iss_stall}, 2'b01);
      tick();
    end
    wb_iss_valid = 1'b1;
    wb_iss_addr = 5'd5;
    @(negedge clock);
    chk("t2_no_bypass", {iss_alu_valid, iss_stall}, 2'b01);
    tick();
    wb_iss_valid = 1'b0;
    @(negedge clock);
    chk("t2_dispatch", {iss_alu_valid, iss_stall, iss_scoreboard}, {2'b10, 32'h0});
    tick();
    // ADDI x8,x1 with rs2 field = 6 (pending) still issues: rs2 unused.
    drive(mk(7'h13, 3'h0, 7'h00, 5'd1, 5'd6, 5'd8, 1'b1, 16'h4000, 32'hFFFF_FFF0));
    @(negedge clock);
    chk("t2_sb6", iss_scoreboard, 32'h40);
    tick();
    id_iss_valid = 1'b0;
    @(negedge clock);
    chk("t2_imm_ignores_rs2", {iss_alu_valid, iss_stall}, 2'b10);
    tick();
    @(negedge clock);
    chk("t2_sb_6_8", iss_scoreboard, 32'h140);
    tick();
    wb(5'd6);
    wb(5'd8);

    // 3: LW x7,4(x1) held by MEM back-pressure while the next instruction waits.
    mem_iss_ready = 1'b0;
    drive(mk(7'h03, 3'h2, 7'h00, 5'd1, 5'd4, 5'd7, 1'b1, 16'h4080, 32'd4));
    tick();
    drive(mk(7'h33, 3'h0, 7'h00, 5'd2, 5'd3, 5'd10, 1'b1, 16'h0000, 32'h0));
    opa_hold = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (c == 0) opa_hold = rf(5'd1);
      chk($sformatf("t3_mem_hold%0d", c),
          {iss_mem_valid, iss_alu_valid, iss_stall, iss_fu_imm, iss_fu_rd, iss_fu_opa},
          {3'b101, 32'd4, 5'd7, opa_hold});
      tick();
    end
    mem_iss_ready = 1'b1;
    @(negedge clock);
    chk("t3_mem_fire", {iss_mem_valid, iss_stall}, 2'b10);
    tick();
    id_iss_valid = 1'b0;
    @(negedge clock);
    chk("t3_next_alu", {iss_alu_valid, iss_scoreboard}, {1'b1, 32'h80});
    tick();
    @(negedge clock);
    chk("t3_sb", iss_scoreboard, 32'h480);
    tick();
    wb(5'd7);
    wb(5'd10);

    // 4: writeback of x9 in the cycle an rd=9 instruction fires: set wins.
    drive(mk(7'h13, 3'h0, 7'h00, 5'd0, 5'd1, 5'd9, 1'b1, 16'h4000, 32'd1));
    tick();
    id_iss_valid = 1'b0;
    wb_iss_valid = 1'b1;
    wb_iss_addr = 5'd9;
    @(negedge clock);
    chk("t4_fire", iss_alu_valid, 1'b1);
    tick();
    wb_iss_valid = 1'b0;
    @(negedge clock);
    chk("t4_set_wins", iss_scoreboard, 32'h200);
    tick();
    wb(5'd12);
    wb(5'd0);
    @(negedge clock);
    chk("t4_wb_nonpending", iss_scoreboard, 32'h200);
    tick();
    wb(5'd9);

    // 5: ADDI x0 tracks nothing; ADD x1,x0,x0 follows back-to-back.
    drive(mk(7'h13, 3'h0, 7'h00, 5'd0, 5'd1, 5'd0, 1'b1, 16'h4000, 32'd1));
    tick();
    drive(mk(7'h33, 3'h0, 7'h00, 5'd0, 5'd0, 5'd1, 1'b1, 16'h0000, 32'h0));
    @(negedge clock);
    chk("t5_addi_fire", {iss_alu_valid, iss_stall}, 2'b10);
    tick();
    id_iss_valid = 1'b0;
    @(negedge clock);
    chk("t5_back_to_back", {iss_alu_valid, iss_stall, iss_scoreboard}, {2'b10, 32'h0});
    tick();
    @(negedge clock);
    chk("t5_sb", iss_scoreboard, 32'h2);
    tick();
    wb(5'd1);

    // 6: async reset while stalled on WAW.
    drive(mk(7'h13, 3'h0, 7'h00, 5'd0, 5'd7, 5'd5, 1'b1, 16'h4000, 32'd7));
    tick();
    drive(mk(7'h13, 3'h0, 7'h00, 5'd0, 5'd2, 5'd5, 1'b1, 16'h4000, 32'd2));
    tick();
    id_iss_valid = 1'b0;
    @(negedge clock);
    chk("t6_waw_stall", {iss_alu_valid, iss_stall, iss_scoreboard}, {2'b01, 32'h20});
    tick();
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_reset", {iss_alu_valid, iss_mem_valid, iss_stall, iss_scoreboard}, 35'd0);
    q.delete();
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_after_reset", {iss_alu_valid, iss_stall, iss_scoreboard}, 34'd0);
    tick();

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
